// File: rtl/multicycle_pkg.sv
// Shared opcodes, state encoding, select codes and control bundle for the
// multicycle MIPS main control unit.
package multicycle_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_e;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RT      = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             i_or_d;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             mem_to_reg;
        logic             reg_dst;
        logic             reg_write;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] pc_source;
        logic [SEL_W-1:0] alu_op;
        logic             addi;
    } ctrl_t;

endpackage

// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle MIPS datapath.
// Optional MULTICYCLE_MEM_WAIT_EN adds mem_ready stalls in FETCH/MEM_READ/MEM_WRITE.
module multicycle_main_control
    import multicycle_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    input  logic [OP_W-1:0]  opcode,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [SEL_W-1:0] ALUSrcB,
    output logic [SEL_W-1:0] PCSource,
    output logic [SEL_W-1:0] ALUop,
    output logic             addi,
    output logic             illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   mem_ok;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and state-decoded controls; illegal_op is the only opcode-dependent output.
    always_comb begin
        state_d    = state_q;
        ctrl       = '0;
        illegal_op = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ok;
                ctrl.pc_write  = mem_ok;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                state_d        = mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                state_d       = mem_ok ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                state_d        = mem_ok ? S_FETCH : S_MEM_WRITE;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_d        = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
                ctrl.addi      = 1'b1;
                state_d        = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign ALUop       = ctrl.alu_op;
    assign addi        = ctrl.addi;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized self-checking bench for multicycle_main_control against an
// instruction-level sequence model; covers MULTICYCLE_MEM_WAIT_EN when defined.
module tb_multicycle_main_control;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ADDI  = 6'b001000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
`ifdef MULTICYCLE_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, addi, illegal_op;
    logic [1:0] ALUSrcB, PCSource, ALUop;
    logic [3:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct { int st; bit rdy; } step_t;
    step_t plan[$];

    always #5 clk = ~clk;

    multicycle_main_control dut (
        .clk(clk), .reset(reset),
`ifdef MULTICYCLE_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .opcode(opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUop(ALUop), .addi(addi), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    task automatic set_ready(input bit r);
`ifdef MULTICYCLE_MEM_WAIT_EN
        mem_ready = r;
`else
        if (r) ; // memory always ready in this build
`endif
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == T_RTYPE || op == T_LW || op == T_SW ||
               op == T_BEQ || op == T_J || op == T_ADDI;
    endfunction

    // Outputs the state table demands: {state, illegal, 17 control bits}.
    function automatic logic [21:0] model_vec(input int st, input bit rdy, input bit ill);
        logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, sa = 0, ad = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00, aop = 2'b00;
        case (st)
            1:  begin mr = 1; irw = rdy; pcw = rdy; sb = 2'b01; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mr = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; iord = 1; end
            7:  begin sa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin sa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
            10: begin pcw = 1; ps = 2'b10; end
            11: begin sa = 1; sb = 2'b10; aop = 2'b10; ad = 1; end
            12: rw = 1;
            default: ;
        endcase
        return {4'(st), ill, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, aop, ad};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {state_dbg, illegal_op, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop, addi};
    endfunction

    task automatic cmp_vec(input string name, input logic [21:0] exp_v);
        n_vec++;
        if (dut_vec() !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                     name, dut_vec(), exp_v, state_dbg, exp_v[21:18]);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp_i);
        n_vec++;
        if (got != exp_i) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp_i);
        end
    endtask

    task automatic push(input int st, input int waits);
        for (int w = 0; w < waits; w++) plan.push_back('{st, 1'b0});
        plan.push_back('{st, 1'b1});
    endtask

    // Entered just after a negedge with the DUT in FETCH; leaves at the next FETCH negedge.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        plan.delete();
        push(1, fw);
        push(2, 0);
        case (op)
            T_LW:    begin push(3, 0); push(4, mw); push(5, 0); end
            T_SW:    begin push(3, 0); push(6, mw); end
            T_RTYPE: begin push(7, 0); push(8, 0); end
            T_BEQ:   push(9, 0);
            T_J:     push(10, 0);
            T_ADDI:  begin push(11, 0); push(12, 0); end
            default: ;
        endcase
        opcode = op;
        foreach (plan[i]) begin
            if (i != 0) @(negedge clk);
            set_ready(plan[i].rdy);
            #1;
            cmp_vec("seq", model_vec(plan[i].st, plan[i].rdy, plan[i].st == 2 && !is_legal(op)));
        end
        @(negedge clk);
        set_ready(1'b1);
    endtask

    // Observes the DUT for one instruction and checks cycle/pulse counts against literals.
    task automatic measure(input string name, input logic [5:0] op, input int mwaits,
                           input int e_lat, input int e_pcw, input int e_rw,
                           input int e_mw, input int e_ill);
        int cyc = 0, pcw = 0, rw = 0, mw = 0, ill = 0, waited = 0;
        bit left = 0, done = 0;
        opcode = op;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i != 0) @(negedge clk);
            if (left && state_dbg == 4'd1) done = 1;
            else begin
                if (state_dbg != 4'd1) left = 1;
                if (state_dbg == 4'd6 && waited < mwaits) begin
                    set_ready(1'b0);
                    waited++;
                end else set_ready(1'b1);
                #1;
                cyc++;
                pcw += int'(PCWrite);
                rw  += int'(RegWrite);
                mw  += int'(MemWrite);
                ill += int'(illegal_op);
            end
        end
        set_ready(1'b1);
        if (!done) cmp_int({name, "_timeout"}, 0, 1);
        cmp_int({name, "_latency"}, cyc, e_lat);
        cmp_int({name, "_pcwrite"}, pcw, e_pcw);
        cmp_int({name, "_regwrite"}, rw, e_rw);
        cmp_int({name, "_memwrite"}, mw, e_mw);
        cmp_int({name, "_illegal"}, ill, e_ill);
    endtask

    initial begin
        logic [5:0] legal_ops [6];
        legal_ops = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
        reset  = 1'b1;
        opcode = 6'd0;
        set_ready(1'b1);
        repeat (2) @(posedge clk);
        #1;
        cmp_vec("reset_state", 22'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        cmp_vec("first_fetch", model_vec(1, 1'b1, 1'b0));
        cmp_int("first_fetch_pcwrite", int'(PCWrite), 1);

        // Hand-computed latencies and pulse counts.
        measure("lw",      T_LW,     0, 5, 1, 1, 0, 0);
        measure("sw",      T_SW,     0, 4, 1, 0, 1, 0);
        measure("rtype",   T_RTYPE,  0, 4, 1, 1, 0, 0);
        measure("addi",    T_ADDI,   0, 4, 1, 1, 0, 0);
        measure("beq",     T_BEQ,    0, 3, 1, 0, 0, 0);
        measure("j",       T_J,      0, 3, 2, 0, 0, 0);
        measure("illegal", 6'b111111, 0, 2, 1, 0, 0, 1);
`ifdef MULTICYCLE_MEM_WAIT_EN
        measure("sw_wait", T_SW,     3, 7, 1, 0, 4, 0);
`endif

        // Model-checked directed sequences.
        run_instr(T_LW, 0, 0);
        run_instr(T_ADDI, 0, 0);
        run_instr(T_BEQ, 0, 0);
        run_instr(6'b111111, 0, 0);

        // Reset asserted while in R_EXEC.
        opcode = T_RTYPE;
        set_ready(1'b1);
        repeat (2) @(negedge clk);
        #1;
        cmp_vec("pre_reset_rexec", model_vec(7, 1'b1, 1'b0));
        reset = 1'b1;
        #1;
        cmp_vec("async_reset", 22'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        cmp_vec("fetch_after_reset", model_vec(1, 1'b1, 1'b0));

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            int fw, mw;
            if ($urandom_range(3, 0) != 0) op = legal_ops[$urandom_range(5, 0)];
            else op = 6'($urandom);
`ifdef MULTICYCLE_MEM_WAIT_EN
            fw = $urandom_range(2, 0);
            mw = $urandom_range(3, 0);
`else
            fw = 0;
            mw = 0;
`endif
            run_instr(op, fw, mw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
